// File: rtl/bus_arbiter_pkg.sv
// Shared CPU memory-side definitions: arbiter states, grant sources and
// default refill burst lengths.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_I,
    REQ_D,
    REQ_W,
    DATA_I,
    DATA_D,
    RESP_W
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D,
    GNT_W
  } grant_t;

  localparam int DEF_I_LEN      = 8;
  localparam int DEF_D_LEN      = 8;
  localparam int DEF_STARVE_MAX = 4;

  // Memory-side length field is "beats minus one".
  function automatic logic [3:0] burst_len_field(input int len);
    return 4'(len - 1);
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Single-outstanding memory arbiter between icache refills, dcache refills
// and uncached dcache stores, with a starvation guard for the I-side.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int I_LEN      = DEF_I_LEN,
  parameter int D_LEN      = DEF_D_LEN,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_rd_req,
  input  logic [31:0] icache_rd_addr,
  output logic        icache_rd_rdy,
  output logic        icache_ret_valid,
  output logic        icache_ret_last,
  output logic [31:0] icache_ret_data,
  input  logic        dcache_rd_req,
  input  logic [31:0] dcache_rd_addr,
  output logic        dcache_rd_rdy,
  output logic        dcache_ret_valid,
  output logic        dcache_ret_last,
  output logic [31:0] dcache_ret_data,
  input  logic        dcache_wr_req,
  input  logic [31:0] dcache_wr_addr,
  input  logic [31:0] dcache_wr_data,
  input  logic [3:0]  dcache_wr_strb,
  output logic        dcache_wr_rdy,
  output logic        dcache_wr_done,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_len,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_rvalid,
  input  logic        mem_rlast,
  input  logic [31:0] mem_rdata,
  input  logic        mem_bvalid,
  output logic        proto_err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0] I_LAST = burst_len_field(I_LEN);
  localparam logic [3:0] D_LAST = burst_len_field(D_LEN);

  arb_state_t    state;
  arb_state_t    state_next;
  grant_t        grant;
  logic [SW-1:0] starve_cnt;
  logic [3:0]    beat_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          proto_err_q;
  logic          rd_beat;
  logic          rd_last;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign proto_err = proto_err_q;

  // Pick a winner in IDLE: stores, then D refills, then I refills, unless the I-side has waited too long.
  always_comb begin
    grant = GNT_NONE;
    if (!rst && state == IDLE) begin
      if (icache_rd_req && starve_cnt == STARVE_LIM) grant = GNT_I;
      else if (dcache_wr_req)                        grant = GNT_W;
      else if (dcache_rd_req)                        grant = GNT_D;
      else if (icache_rd_req)                        grant = GNT_I;
    end
  end

  // Next state plus all handshake outputs; everything is held low while reset is asserted.
  always_comb begin
    state_next       = state;
    icache_rd_rdy    = 1'b0;
    icache_ret_valid = 1'b0;
    icache_ret_last  = 1'b0;
    icache_ret_data  = '0;
    dcache_rd_rdy    = 1'b0;
    dcache_ret_valid = 1'b0;
    dcache_ret_last  = 1'b0;
    dcache_ret_data  = '0;
    dcache_wr_rdy    = 1'b0;
    dcache_wr_done   = 1'b0;
    mem_req          = 1'b0;
    mem_wr           = 1'b0;
    mem_len          = '0;
    rd_beat          = 1'b0;
    rd_last          = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          case (grant)
            GNT_I: begin
              icache_rd_rdy = 1'b1;
              state_next    = REQ_I;
            end
            GNT_D: begin
              dcache_rd_rdy = 1'b1;
              state_next    = REQ_D;
            end
            GNT_W: begin
              dcache_wr_rdy = 1'b1;
              state_next    = REQ_W;
            end
            default: ;
          endcase
        end
        REQ_I: begin
          mem_req = 1'b1;
          mem_len = I_LAST;
          if (mem_addr_ok) state_next = DATA_I;
        end
        REQ_D: begin
          mem_req = 1'b1;
          mem_len = D_LAST;
          if (mem_addr_ok) state_next = DATA_D;
        end
        REQ_W: begin
          mem_req = 1'b1;
          mem_wr  = 1'b1;
          if (mem_addr_ok) state_next = RESP_W;
        end
        DATA_I: begin
          rd_beat          = mem_rvalid;
          rd_last          = mem_rvalid && (beat_cnt == I_LAST);
          icache_ret_valid = mem_rvalid;
          icache_ret_data  = mem_rdata;
          icache_ret_last  = rd_last;
          if (rd_last) state_next = IDLE;
        end
        DATA_D: begin
          rd_beat          = mem_rvalid;
          rd_last          = mem_rvalid && (beat_cnt == D_LAST);
          dcache_ret_valid = mem_rvalid;
          dcache_ret_data  = mem_rdata;
          dcache_ret_last  = rd_last;
          if (rd_last) state_next = IDLE;
        end
        RESP_W: begin
          dcache_wr_done = mem_bvalid;
          if (mem_bvalid) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the winner's address (and store payload) at grant time so mem_* stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (grant)
        GNT_I: addr_q <= icache_rd_addr;
        GNT_D: addr_q <= dcache_rd_addr;
        GNT_W: begin
          addr_q  <= dcache_wr_addr;
          wdata_q <= dcache_wr_data;
          wstrb_q <= dcache_wr_strb;
        end
        default: ;
      endcase
    end
  end

  // Count D-side wins while the I-side is waiting; any I win or an idle I-side clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant == GNT_I || !icache_rd_req)
        starve_cnt <= '0;
      else if ((grant == GNT_D || grant == GNT_W) && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Beat counter: cleared when the read is accepted, advanced on every valid beat.
  always_ff @(posedge clk) begin
    if (rst)
      beat_cnt <= '0;
    else if ((state == REQ_I || state == REQ_D) && mem_addr_ok)
      beat_cnt <= '0;
    else if (rd_beat)
      beat_cnt <= beat_cnt + 4'd1;
  end

  // Sticky flag for a memory last-beat marker that disagrees with our own beat count.
  always_ff @(posedge clk) begin
    if (rst)
      proto_err_q <= 1'b0;
    else if (rd_beat && (mem_rlast != rd_last))
      proto_err_q <= 1'b1;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_bus_arbiter;

  localparam int I_LEN      = 8;
  localparam int D_LEN      = 8;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic        rst;
    logic        icache_rd_req;
    logic [31:0] icache_rd_addr;
    logic        dcache_rd_req;
    logic [31:0] dcache_rd_addr;
    logic        dcache_wr_req;
    logic [31:0] dcache_wr_addr;
    logic [31:0] dcache_wr_data;
    logic [3:0]  dcache_wr_strb;
    logic        mem_addr_ok;
    logic        mem_rvalid;
    logic        mem_rlast;
    logic [31:0] mem_rdata;
    logic        mem_bvalid;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_rd_req = 1'b0;
  logic [31:0] icache_rd_addr = '0;
  logic        dcache_rd_req = 1'b0;
  logic [31:0] dcache_rd_addr = '0;
  logic        dcache_wr_req = 1'b0;
  logic [31:0] dcache_wr_addr = '0;
  logic [31:0] dcache_wr_data = '0;
  logic [3:0]  dcache_wr_strb = '0;
  logic        mem_addr_ok = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rlast = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_bvalid = 1'b0;

  logic        icache_rd_rdy, icache_ret_valid, icache_ret_last;
  logic [31:0] icache_ret_data;
  logic        dcache_rd_rdy, dcache_ret_valid, dcache_ret_last;
  logic [31:0] dcache_ret_data;
  logic        dcache_wr_rdy, dcache_wr_done;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_len, mem_wstrb;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who owns the bus, whether memory took the
  // request, how many beats have arrived, and the I-side wait count.
  bit          m_busy = 0;
  bit          m_acc = 0;
  int          m_kind = 0;
  int          m_beats = 0;
  int          m_starve = 0;
  bit          m_proto = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;

  bus_arbiter #(.I_LEN(I_LEN), .D_LEN(D_LEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid),
    .icache_ret_last(icache_ret_last), .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
    .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid),
    .dcache_ret_last(dcache_ret_last), .dcache_ret_data(dcache_ret_data),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
    .dcache_wr_data(dcache_wr_data), .dcache_wr_strb(dcache_wr_strb),
    .dcache_wr_rdy(dcache_wr_rdy), .dcache_wr_done(dcache_wr_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok),
    .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast), .mem_rdata(mem_rdata),
    .mem_bvalid(mem_bvalid), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic int modelLen(input int kind);
    return (kind == 1) ? I_LEN : (kind == 2) ? D_LEN : 1;
  endfunction

  function automatic bit modelLastNow();
    return m_busy && m_acc && m_kind != 3 && (m_beats == modelLen(m_kind) - 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for this cycle, then advance the model.
  task automatic modelCycle();
    int win;
    bit lastflag, indata, e_req;
    win = 0;
    if (!rst && !m_busy) begin
      if (icache_rd_req && m_starve == STARVE_MAX) win = 1;
      else if (dcache_wr_req) win = 3;
      else if (dcache_rd_req) win = 2;
      else if (icache_rd_req) win = 1;
    end
    lastflag = (m_beats == modelLen(m_kind) - 1);
    indata   = !rst && m_busy && m_acc && m_kind != 3;
    e_req    = !rst && m_busy && !m_acc;

    checkOutput("icache_rd_rdy", icache_rd_rdy, 32'(win == 1));
    checkOutput("dcache_rd_rdy", dcache_rd_rdy, 32'(win == 2));
    checkOutput("dcache_wr_rdy", dcache_wr_rdy, 32'(win == 3));
    checkOutput("icache_ret_valid", icache_ret_valid, 32'(indata && m_kind == 1 && mem_rvalid));
    checkOutput("icache_ret_last", icache_ret_last, 32'(indata && m_kind == 1 && mem_rvalid && lastflag));
    checkOutput("dcache_ret_valid", dcache_ret_valid, 32'(indata && m_kind == 2 && mem_rvalid));
    checkOutput("dcache_ret_last", dcache_ret_last, 32'(indata && m_kind == 2 && mem_rvalid && lastflag));
    if (indata && m_kind == 1 && mem_rvalid) checkOutput("icache_ret_data", icache_ret_data, mem_rdata);
    if (indata && m_kind == 2 && mem_rvalid) checkOutput("dcache_ret_data", dcache_ret_data, mem_rdata);
    checkOutput("dcache_wr_done", dcache_wr_done,
                32'(!rst && m_busy && m_acc && m_kind == 3 && mem_bvalid));
    checkOutput("mem_req", mem_req, 32'(e_req));
    checkOutput("mem_wr", mem_wr, 32'(e_req && m_kind == 3));
    if (e_req) begin
      checkOutput("mem_len", mem_len, 32'(modelLen(m_kind) - 1));
      checkOutput("mem_addr", mem_addr, m_addr);
      if (m_kind == 3) begin
        checkOutput("mem_wdata", mem_wdata, m_wdata);
        checkOutput("mem_wstrb", mem_wstrb, 32'(m_wstrb));
      end
    end
    checkOutput("proto_err", proto_err, 32'(m_proto));

    if (rst) begin
      m_busy = 0; m_acc = 0; m_kind = 0; m_beats = 0; m_starve = 0; m_proto = 0;
      m_addr = '0; m_wdata = '0; m_wstrb = '0;
    end else if (!m_busy) begin
      if (win != 0) begin
        m_busy = 1; m_acc = 0; m_kind = win;
        m_addr = (win == 1) ? icache_rd_addr : (win == 2) ? dcache_rd_addr : dcache_wr_addr;
        if (win == 3) begin
          m_wdata = dcache_wr_data;
          m_wstrb = dcache_wr_strb;
        end
      end
      if (win == 1 || !icache_rd_req) m_starve = 0;
      else if (win != 0 && m_starve < STARVE_MAX) m_starve++;
    end else if (!m_acc) begin
      if (mem_addr_ok) begin
        m_acc = 1;
        m_beats = 0;
      end
    end else if (m_kind == 3) begin
      if (mem_bvalid) m_busy = 0;
    end else if (mem_rvalid) begin
      if (mem_rlast != lastflag) m_proto = 1;
      m_beats++;
      if (lastflag) m_busy = 0;
    end
  endtask

  // Drive one cycle's inputs just after the clock edge, then check at the falling edge.
  task automatic applyStimulus(input stim_t st);
    @(posedge clk);
    #1;
    rst            = st.rst;
    icache_rd_req  = st.icache_rd_req;
    icache_rd_addr = st.icache_rd_addr;
    dcache_rd_req  = st.dcache_rd_req;
    dcache_rd_addr = st.dcache_rd_addr;
    dcache_wr_req  = st.dcache_wr_req;
    dcache_wr_addr = st.dcache_wr_addr;
    dcache_wr_data = st.dcache_wr_data;
    dcache_wr_strb = st.dcache_wr_strb;
    mem_addr_ok    = st.mem_addr_ok;
    mem_rvalid     = st.mem_rvalid;
    mem_rlast      = st.mem_rlast;
    mem_rdata      = st.mem_rdata;
    mem_bvalid     = st.mem_bvalid;
    @(negedge clk);
    modelCycle();
  endtask

  task automatic grantAndAccept(input logic ireq, input logic drd, input logic dwr,
                                input logic [31:0] a, input int delay, output int who,
                                output logic [3:0] len_s, output logic [31:0] addr_s,
                                output logic wr_s);
    stim_t st;
    st = '0;
    st.icache_rd_req  = ireq;
    st.dcache_rd_req  = drd;
    st.dcache_wr_req  = dwr;
    st.icache_rd_addr = a;
    st.dcache_rd_addr = a;
    st.dcache_wr_addr = a;
    st.dcache_wr_data = 32'hCAFE0001;
    st.dcache_wr_strb = 4'hC;
    applyStimulus(st);
    who = icache_rd_rdy ? 1 : dcache_rd_rdy ? 2 : dcache_wr_rdy ? 3 : 0;
    st.dcache_rd_req = 1'b0;
    st.dcache_wr_req = 1'b0;
    len_s = '0; addr_s = '0; wr_s = 1'b0;
    for (int k = 0; k <= delay; k++) begin
      st.mem_addr_ok = (k == delay);
      applyStimulus(st);
      if (k == 0) begin
        len_s  = mem_len;
        addr_s = mem_addr;
        wr_s   = mem_wr;
      end
    end
  endtask

  task automatic runBurst(input int side, input int len, input int last_at,
                          output int nvalid, output int last_idx);
    stim_t st;
    nvalid = 0;
    last_idx = -1;
    for (int b = 0; b < len; b++) begin
      st = '0;
      st.mem_rvalid = 1'b1;
      st.mem_rdata  = $urandom;
      st.mem_rlast  = (b == last_at);
      applyStimulus(st);
      if (side == 1) begin
        if (icache_ret_valid) nvalid++;
        if (icache_ret_last) last_idx = b;
      end else begin
        if (dcache_ret_valid) nvalid++;
        if (dcache_ret_last) last_idx = b;
      end
    end
  endtask

  initial begin
    stim_t st;
    int who, nvalid, last_idx;
    logic [3:0] len_s;
    logic [31:0] addr_s;
    logic wr_s;
    int exp_seq [6];
    exp_seq = '{2, 2, 2, 2, 1, 2};

    st = '0;
    st.rst = 1'b1;
    applyStimulus(st);
    st = '0;
    applyStimulus(st);
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_mem_wr", mem_wr, 0);
    checkOutput("reset_proto_err", proto_err, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);

    $display("[TB] icache refill with delayed accept");
    grantAndAccept(1'b1, 1'b0, 1'b0, 32'h1FC00000, 2, who, len_s, addr_s, wr_s);
    checkOutput("i_grant", 32'(who), 1);
    checkOutput("i_mem_len", 32'(len_s), 7);
    checkOutput("i_mem_addr", addr_s, 32'h1FC00000);
    checkOutput("i_mem_wr", 32'(wr_s), 0);
    runBurst(1, 8, 7, nvalid, last_idx);
    checkOutput("i_beat_count", 32'(nvalid), 8);
    checkOutput("i_last_beat", 32'(last_idx), 7);

    $display("[TB] stray memory responses while idle");
    st = '0;
    st.mem_rvalid = 1'b1;
    st.mem_bvalid = 1'b1;
    applyStimulus(st);
    checkOutput("stray_i_valid", icache_ret_valid, 0);
    checkOutput("stray_d_valid", dcache_ret_valid, 0);
    checkOutput("stray_wr_done", dcache_wr_done, 0);

    $display("[TB] store beats simultaneous icache refill");
    grantAndAccept(1'b1, 1'b0, 1'b1, 32'h00001000, 0, who, len_s, addr_s, wr_s);
    checkOutput("w_grant", 32'(who), 3);
    checkOutput("w_mem_wr", 32'(wr_s), 1);
    checkOutput("w_mem_len", 32'(len_s), 0);
    st = '0;
    st.icache_rd_req = 1'b1;
    applyStimulus(st);
    checkOutput("w_wait_no_i_rdy", icache_rd_rdy, 0);
    st.mem_bvalid = 1'b1;
    applyStimulus(st);
    checkOutput("w_done", dcache_wr_done, 1);
    checkOutput("w_done_no_i_rdy", icache_rd_rdy, 0);
    grantAndAccept(1'b1, 1'b0, 1'b0, 32'h00002000, 0, who, len_s, addr_s, wr_s);
    checkOutput("i_after_w", 32'(who), 1);
    runBurst(1, 8, 7, nvalid, last_idx);

    $display("[TB] starvation guard");
    for (int g = 0; g < 6; g++) begin
      grantAndAccept(1'b1, 1'b1, 1'b0, 32'h00003000 + 32'(g * 64), 0, who, len_s, addr_s, wr_s);
      checkOutput($sformatf("starve_grant_%0d", g), 32'(who), 32'(exp_seq[g]));
      runBurst(who, 8, 7, nvalid, last_idx);
    end

    $display("[TB] early memory last marker on dcache refill");
    grantAndAccept(1'b0, 1'b1, 1'b0, 32'h00004000, 0, who, len_s, addr_s, wr_s);
    runBurst(2, 8, 5, nvalid, last_idx);
    checkOutput("perr_beats", 32'(nvalid), 8);
    checkOutput("perr_last_beat", 32'(last_idx), 7);
    checkOutput("perr_flag", proto_err, 1);

    $display("[TB] reset in the middle of a dcache refill");
    grantAndAccept(1'b0, 1'b1, 1'b0, 32'h00005000, 0, who, len_s, addr_s, wr_s);
    for (int b = 0; b < 3; b++) begin
      st = '0;
      st.mem_rvalid = 1'b1;
      st.mem_rdata  = $urandom;
      st.rst        = (b == 2);
      applyStimulus(st);
    end
    st = '0;
    st.mem_rvalid = 1'b1;
    applyStimulus(st);
    checkOutput("abort_d_valid", dcache_ret_valid, 0);
    checkOutput("abort_d_last", dcache_ret_last, 0);
    checkOutput("abort_mem_req", mem_req, 0);
    checkOutput("abort_proto_err", proto_err, 0);
    checkOutput("abort_mem_addr", mem_addr, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      st = '0;
      st.rst            = ($urandom_range(0, 299) == 0);
      st.icache_rd_req  = ($urandom_range(0, 9) < 4);
      st.icache_rd_addr = {$urandom} & 32'hFFFFFFE0;
      st.dcache_rd_req  = ($urandom_range(0, 9) < 4);
      st.dcache_rd_addr = {$urandom} & 32'hFFFFFFE0;
      st.dcache_wr_req  = ($urandom_range(0, 9) < 2);
      st.dcache_wr_addr = {$urandom} & 32'hFFFFFFFC;
      st.dcache_wr_data = $urandom;
      st.dcache_wr_strb = 4'($urandom_range(1, 15));
      st.mem_addr_ok    = ($urandom_range(0, 1) == 1);
      st.mem_rvalid     = ($urandom_range(0, 9) < 6);
      st.mem_rlast      = modelLastNow() ^ ($urandom_range(0, 49) == 0);
      st.mem_rdata      = $urandom;
      st.mem_bvalid     = ($urandom_range(0, 9) < 4);
      applyStimulus(st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameters SHALL be, one per line:
  I_LEN, 8, icache refill burst length in words (power of 2, 1..16)
  D_LEN, 8, dcache refill burst length in words (power of 2, 1..16)
  STARVE_MAX, 4, consecutive D-side grants allowed while I-side waits
REQ-003 Ports SHALL be, one per line:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  icache_rd_req  in  1  icache refill request
  icache_rd_addr  in  32  line-aligned refill address
  icache_rd_rdy  out  1  request accepted (1-cycle pulse)
  icache_ret_valid  out  1  refill data beat valid
  icache_ret_last  out  1  final beat of refill
  icache_ret_data  out  32  refill data
  dcache_rd_req  in  1  dcache refill request
  dcache_rd_addr  in  32  line-aligned refill address
  dcache_rd_rdy  out  1  request accepted (1-cycle pulse)
  dcache_ret_valid  out  1  refill data beat valid
  dcache_ret_last  out  1  final beat of refill
  dcache_ret_data  out  32  refill data
  dcache_wr_req  in  1  uncached single-word store request
  dcache_wr_addr  in  32  store address
  dcache_wr_data  in  32  store data
  dcache_wr_strb  in  4  byte enables
  dcache_wr_rdy  out  1  store accepted (1-cycle pulse)
  dcache_wr_done  out  1  store acknowledged by memory (1-cycle pulse)
  mem_req  out  1  memory request valid
  mem_wr  out  1  1 = write, 0 = read
  mem_addr  out  32  request address
  mem_len  out  4  burst beats minus 1
  mem_wdata  out  32  write data
  mem_wstrb  out  4  write byte enables
  mem_addr_ok  in  1  memory accepted request this cycle
  mem_rvalid  in  1  read beat valid
  mem_rlast  in  1  memory-side last-beat marker
  mem_rdata  in  32  read beat data
  mem_bvalid  in  1  write acknowledge
  proto_err  out  1  sticky: mem_rlast disagreed with internal beat count

Function
REQ-004 FSM states SHALL be IDLE, REQ_I, REQ_D, REQ_W, DATA_I, DATA_D, RESP_W; exactly one transaction outstanding.
REQ-005 In IDLE, grant priority SHALL be dcache_wr_req > dcache_rd_req > icache_rd_req, except when starve_cnt == STARVE_MAX and icache_rd_req=1, then I-side wins.
REQ-006 On grant the block SHALL pulse the winner's *_rdy, latch address/data/strb, and enter REQ_x; mem_req SHALL rise the following cycle.
REQ-007 In REQ_x, mem_req and all mem_* fields SHALL hold stable until mem_addr_ok=1; then next state DATA_I, DATA_D or RESP_W.
REQ-008 mem_len SHALL be I_LEN-1 (REQ_I), D_LEN-1 (REQ_D), 0 (REQ_W); mem_wr=1 only in REQ_W.
REQ-009 In DATA_x, x_ret_valid SHALL equal mem_rvalid combinationally with x_ret_data=mem_rdata; the other side's ret_valid SHALL be 0.
REQ-010 A 4-bit beat counter SHALL clear on entering DATA_x, increment per mem_rvalid; x_ret_last=1 when counter==LEN-1 and mem_rvalid=1; state returns to IDLE on that beat.
REQ-011 If mem_rlast differs from the internal last condition on any valid beat, proto_err SHALL set and hold until rst; counter remains authoritative.
REQ-012 In RESP_W, mem_bvalid SHALL pulse dcache_wr_done and return to IDLE.
REQ-013 starve_cnt SHALL increment (saturating at STARVE_MAX) on each D-side grant while icache_rd_req=1, and clear on any I-side grant or when icache_rd_req=0 in IDLE.
REQ-014 A request deasserted before its *_rdy pulse SHALL be dropped without side effects; requests arriving outside IDLE SHALL wait.
REQ-015 mem_rvalid/mem_bvalid outside DATA_x/RESP_W SHALL be ignored.

Reset
REQ-016 On rst: state=IDLE, starve_cnt=0, beat counter=0, proto_err=0, all *_rdy, *_ret_valid, *_ret_last, dcache_wr_done, mem_req, mem_wr = 0; latched address/data = 0.
REQ-017 Reset mid-transaction SHALL abort it; the memory model is reset concurrently.

Structure
REQ-018 State enum, grant-source encoding and default burst lengths SHALL live in the shared CPU package.
REQ-019 No sub-module; beat counter and starvation counter are inline.

Verification
REQ-020 icache_rd_req at 0x1FC00000, mem_addr_ok delay 2 -> mem_len=7, 8 icache_ret_valid beats, ret_last on beat 8, back to IDLE.
REQ-021 dcache_wr_req and icache_rd_req same cycle -> dcache_wr_rdy first, mem_wr=1 mem_len=0; icache_rd_rdy only after dcache_wr_done.
REQ-022 icache_rd_req held plus 5 back-to-back dcache_rd_req -> 4 D grants, then I grant, starve_cnt back to 0.
REQ-023 Memory asserts mem_rlast on beat 6 of an 8-beat D refill -> proto_err=1, dcache_ret_last still on beat 8.
REQ-024 rst asserted during DATA_D beat 3 -> next cycle all outputs at reset values, state IDLE.
REQ-025 mem_rvalid injected in IDLE -> no ret_valid on either side.
